sum_loop_sequencer: RTL



---
 rtl/sum_loop_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sum_loop_sequencer.sv
// Start/done Moore controller driving the register-file/adder datapath through the accumulate
// loop. Define ITER_GUARD_EN to stop the loop and flag err once MAX_ITER iterations complete.
`timescale 1ns/1ps
module sum_loop_sequencer #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned MAX_ITER = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              cmp_le_i,
   output logic              rf_src_sel_o,
   output logic [ADDR_W-1:0] raddr1_o,
   output logic [ADDR_W-1:0] raddr2_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic              we_o,
   output logic              out_en_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  iter_cnt_o
);

   localparam logic [ADDR_W-1:0] RegR1 = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] RegR2 = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] RegR3 = ADDR_W'(3);

`ifdef ITER_GUARD_EN
   localparam bit GuardEn = 1'b1;
`else
   localparam bit GuardEn = 1'b0;
`endif

   typedef enum logic [3:0] {
      StIdle, StClr1, StClr2, StLd1, StTest, StAcc, StInc, StOut, StDone
   } state_e;

   state_e              state_q, state_d;
   logic                set_err;
   logic                at_cap;
   logic                src_q, src_d;
   logic [ADDR_W-1:0]   raddr1_q, raddr1_d;
   logic [ADDR_W-1:0]   raddr2_q, raddr2_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic                we_q, we_d;
   logic                out_en_q, out_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q;
   logic [CNT_W-1:0]    iter_cnt_q;

   assign at_cap = (iter_cnt_q == CNT_W'(MAX_ITER));

   always_comb begin
      state_d = state_q;
      set_err = 1'b0;
      unique case (state_q)
         StIdle: if (start_i) state_d = StClr1;
         StClr1: state_d = StClr2;
         StClr2: state_d = StLd1;
         StLd1:  state_d = StTest;
         StTest: begin
            if (cmp_le_i && GuardEn && at_cap) begin
               state_d = StDone;
               set_err = 1'b1;
            end else if (cmp_le_i) begin
               state_d = StAcc;
            end else begin
               state_d = StDone;
            end
         end
         StAcc:  state_d = StInc;
         StInc:  state_d = StOut;
         StOut:  state_d = StTest;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort overrides every successor, including the comparator decision.
      if (stop_i && (state_q inside {StClr1, StClr2, StLd1, StTest, StAcc, StInc, StOut})) begin
         state_d = StDone;
         set_err = 1'b1;
      end
   end

   // Outputs are decoded from the next state and registered, so they track state_q exactly.
   always_comb begin
      src_d    = 1'b0;
      raddr1_d = '0;
      raddr2_d = '0;
      waddr_d  = '0;
      we_d     = 1'b0;
      out_en_d = 1'b0;
      busy_d   = (state_d != StIdle);
      done_d   = 1'b0;
      case (state_d)
         StClr1: begin
            waddr_d = RegR1;
            we_d    = 1'b1;
         end
         StClr2: begin
            waddr_d = RegR2;
            we_d    = 1'b1;
         end
         StLd1: begin
            src_d   = 1'b1;
            waddr_d = RegR3;
            we_d    = 1'b1;
         end
         StTest: raddr1_d = RegR1;
         StAcc: begin
            raddr1_d = RegR1;
            raddr2_d = RegR2;
            waddr_d  = RegR2;
            we_d     = 1'b1;
         end
         StInc: begin
            raddr1_d = RegR1;
            raddr2_d = RegR3;
            waddr_d  = RegR1;
            we_d     = 1'b1;
         end
         StOut: begin
            raddr1_d = RegR2;
            out_en_d = 1'b1;
         end
         StDone: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         src_q      <= 1'b0;
         raddr1_q   <= '0;
         raddr2_q   <= '0;
         waddr_q    <= '0;
         we_q       <= 1'b0;
         out_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         iter_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         raddr1_q <= raddr1_d;
         raddr2_q <= raddr2_d;
         waddr_q  <= waddr_d;
         we_q     <= we_d;
         out_en_q <= out_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         if (state_q == StIdle && start_i) begin
            err_q      <= 1'b0;
            iter_cnt_q <= '0;
         end else begin
            if (set_err) err_q <= 1'b1;
            if (state_q == StOut && iter_cnt_q != {CNT_W{1'b1}}) begin
               iter_cnt_q <= iter_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign rf_src_sel_o = src_q;
   assign raddr1_o     = raddr1_q;
   assign raddr2_o     = raddr2_q;
   assign waddr_o      = waddr_q;
   assign we_o         = we_q;
   assign out_en_o     = out_en_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign iter_cnt_o   = iter_cnt_q;

endmodule
